// File: rtl/imem_block_responder.sv
// Instruction-memory responder: 1 KiB byte store served as 16-byte blocks over READ/BUSYWAIT.
// Fixed LATENCY stall per fetch; byte load port writes the store only while idle.
module imem_block_responder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic [5:0]   ADDRESS,
  output logic [127:0] READDATA,
  output logic         BUSYWAIT,
  input  logic         LOADEN,
  input  logic [9:0]   LOADADDR,
  input  logic [7:0]   LOADDATA
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [7:0] CntInit = 8'(LATENCY - 1);

  state_e         state_q, state_d;
  logic [5:0]     addr_q, addr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [127:0]   rdata_q, rdata_d;
  logic [127:0]   block;
  logic           load_en;

  logic [7:0]     mem [1024];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Store is deliberately not cleared by RESET.
  always_ff @(posedge CLK) begin
    if (load_en) begin
      mem[LOADADDR] <= LOADDATA;
    end
  end

  always_comb begin
    block = '0;
    for (int k = 0; k < 16; k++) begin
      block[8*k +: 8] = mem[{addr_q, 4'(k)}];
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (READ) begin
          addr_d  = ADDRESS;
          cnt_d   = CntInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!READ) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          rdata_d = block;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs; a READ in the same idle cycle as LOADEN wins over the load.
  always_comb begin
    BUSYWAIT = READ && !RESET && (state_q != StDone);
    READDATA = rdata_q;
    load_en  = LOADEN && !RESET && !READ && (state_q == StIdle);
  end

endmodule

// File: tb/tb_imem_block_responder.sv
// Self-checking bench for imem_block_responder: vector table, corner sequences, random fetches
// against a byte-array reference model.
module tb_imem_block_responder;

  localparam int unsigned L = 4;
  localparam int P = 10;

  logic         CLK = 1'b0;
  logic         RESET, READ, LOADEN, BUSYWAIT;
  logic [5:0]   ADDRESS;
  logic [9:0]   LOADADDR;
  logic [7:0]   LOADDATA;
  logic [127:0] READDATA;

  imem_block_responder #(.LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .LOADEN(LOADEN), .LOADADDR(LOADADDR), .LOADDATA(LOADDATA)
  );

  always #(P/2) CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]   mem_m [1024];
  logic [127:0] last_rd;

  typedef struct {
    logic [5:0]   addr;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [9:0] x;
    x = 10'(a);
    return x[7:0] ^ {4{x[9:8]}};
  endfunction

  function automatic logic [127:0] model_block(input logic [5:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = mem_m[int'(b) * 16 + k];
    return r;
  endfunction

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    @(negedge CLK);
    LOADEN = 1'b1; LOADADDR = a; LOADDATA = d;
    @(posedge CLK);
    #1 LOADEN = 1'b0;
    mem_m[a] = d;
  endtask

  // Counts edges until BUSYWAIT is seen low; returns at the negedge of the data cycle.
  task automatic wait_low(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end while (BUSYWAIT && n < 300);
  endtask

  task automatic fetch(input logic [5:0] a, output logic [127:0] d, output int n,
                       output time t_acc);
    @(negedge CLK);
    READ = 1'b1; ADDRESS = a;
    #1 chk("bw_rise", 128'(BUSYWAIT), 128'(1'b1));
    @(posedge CLK);
    t_acc = $time;
    n = 1;
    @(negedge CLK);
    while (BUSYWAIT && n < 300) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end
    d = READDATA;
    @(posedge CLK);
    #1 READ = 1'b0;
  endtask

  initial begin
    logic [127:0] d, d2, exp;
    int n, n2;
    time t1, t2;
    RESET = 1'b1; READ = 1'b0; LOADEN = 1'b0;
    ADDRESS = '0; LOADADDR = '0; LOADDATA = '0;
    last_rd = '0;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rdata", READDATA, 128'h0);
    chk("reset_busy", 128'(BUSYWAIT), 128'h0);
    READ = 1'b1;
    #1 chk("reset_blocks_busy", 128'(BUSYWAIT), 128'h0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    for (int a = 0; a < 1024; a++) load(10'(a), pat(a));

    vecs[0] = '{6'h01, 128'h1F1E1D1C1B1A19181716151413121110};
    vecs[1] = '{6'h3F, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[2] = '{6'h00, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[3] = '{6'h10, model_block(6'h10)};
    vecs[4] = '{6'h2A, model_block(6'h2A)};
    for (int i = 0; i < 5; i++) begin
      fetch(vecs[i].addr, d, n, t1);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 128'(n), 128'(L + 1));
      last_rd = vecs[i].exp;
    end

    // Data valid one cycle only; READ held after it is re-accepted.
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'h03;
    wait_low(n);
    chk("once_lat", 128'(n), 128'(L + 1));
    chk("once_data", READDATA, model_block(6'h03));
    @(posedge CLK);
    #1 chk("reaccept_busy", 128'(BUSYWAIT), 128'h1);
    ADDRESS = 6'h04;
    wait_low(n);
    chk("reaccept_lat", 128'(n), 128'(L + 1));
    chk("reaccept_data", READDATA, model_block(6'h04));
    last_rd = model_block(6'h04);
    @(posedge CLK);
    #1 READ = 1'b0;

    // ADDRESS change mid-ACCESS ignored
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'h3F;
    repeat (2) @(posedge CLK);
    #1 ADDRESS = 6'h00;
    wait_low(n);
    chk("addr_latched", READDATA, model_block(6'h3F));
    last_rd = model_block(6'h3F);
    @(posedge CLK);
    #1 READ = 1'b0;

    // RESET mid-ACCESS
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'h07;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_rdata", READDATA, 128'h0);
    chk("rst_mid_busy", 128'(BUSYWAIT), 128'h0);
    RESET = 1'b0; READ = 1'b0;
    last_rd = '0;
    fetch(6'h07, d, n, t1);
    chk("post_rst_data", d, model_block(6'h07));
    chk("post_rst_lat", 128'(n), 128'(L + 1));
    last_rd = d;

    // Abort holds READDATA
    fetch(6'h09, d, n, t1);
    last_rd = d;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 6'h0A;
    repeat (2) @(posedge CLK);
    #1 READ = 1'b0;
    repeat (L + 2) @(posedge CLK);
    #1 chk("abort_hold", READDATA, last_rd);
    fetch(6'h0A, d, n, t1);
    chk("after_abort_lat", 128'(n), 128'(L + 1));
    chk("after_abort_data", d, model_block(6'h0A));

    // LOADEN with READ and during ACCESS is ignored
    @(negedge CLK);
    LOADEN = 1'b1; LOADADDR = 10'h0B0; LOADDATA = ~mem_m[10'h0B0];
    READ = 1'b1; ADDRESS = 6'h0B;
    wait_low(n);
    chk("load_ignored_a", READDATA, model_block(6'h0B));
    @(posedge CLK);
    #1 READ = 1'b0; LOADEN = 1'b0;
    fetch(6'h0B, d, n, t1);
    chk("load_ignored_b", d, model_block(6'h0B));
    load(10'h0B0, 8'hA5);
    fetch(6'h0B, d, n, t1);
    chk("load_effect", d, model_block(6'h0B));
    last_rd = d;

    // Back-to-back fetches
    fetch(6'h02, d, n, t1);
    fetch(6'h05, d2, n2, t2);
    chk("b2b_first", d, model_block(6'h02));
    chk("b2b_second", d2, model_block(6'h05));
    chk("b2b_spacing", 128'((t2 - t1) / P), 128'(L + 2));
    last_rd = d2;

    // Randomized operations against the model
    for (int it = 0; it < 150; it++) begin
      int op;
      logic [5:0] b;
      op = int'($urandom_range(0, 2));
      b = 6'($urandom);
      if (op == 0) begin
        load(10'($urandom), 8'($urandom));
      end else if (op == 1) begin
        exp = model_block(b);
        fetch(b, d, n, t1);
        chk($sformatf("rnd%0d_data", it), d, exp);
        chk($sformatf("rnd%0d_lat", it), 128'(n), 128'(L + 1));
        last_rd = exp;
      end else begin
        @(negedge CLK);
        READ = 1'b1; ADDRESS = b;
        repeat ($urandom_range(1, L)) @(posedge CLK);
        #1 READ = 1'b0;
        @(posedge CLK);
        #1 chk($sformatf("rnd%0d_abort", it), READDATA, last_rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #(P * 60000);
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/imem_block_responder.md
# imem_block_responder

Instruction-memory responder serving 128-bit, 16-byte blocks to the instruction cache over the READ/BUSYWAIT block-fetch interface. It holds a 1 KiB byte-addressed instruction store (64 blocks), accepts a 6-bit block address, and stalls the requester for a fixed parameterised latency. It then presents the block for exactly one cycle with BUSYWAIT low. A byte-wide load port fills the store from the bench or boot logic while the responder is idle.

## Interface
- LATENCY, 4: clock edges from request acceptance to data valid; legal range 1..255.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  block fetch request from the instruction cache; held high until BUSYWAIT is seen low.
- ADDRESS  in  6  block address {tag, index}; sampled when the request is accepted.
- READDATA  out  128  fetched block; byte k of the block on bits [8k+7:8k], so word 0 is bits [31:0].
- BUSYWAIT  out  1  stall to the requester.
- LOADEN  in  1  write one byte into the store.
- LOADADDR  in  10  byte address for the load.
- LOADDATA  in  8  byte to write.

## Operation
- Storage: 1024 x 8 array; block b = bytes 16b..16b+15. RESET does not clear the array.
- Registers: state, latched block address, down-counter of width 8, and the READDATA register.
- BUSYWAIT is combinational: READ && !RESET && state != DONE. It therefore rises in the same cycle READ rises, before the requester's next sampling edge.
- States:
  - IDLE: if READ is high at the edge, latch ADDRESS, set counter = LATENCY-1, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: if READ is low at the edge, abort to IDLE with READDATA unchanged. Else if counter == 0, load READDATA from block[latched address] and go to DONE. Else decrement the counter.
  - DONE: BUSYWAIT is low and READDATA is valid. At the next edge go to IDLE unconditionally.
- ADDRESS changes during ACCESS are ignored; the latched address is used.
- READDATA holds its value until the next completed fetch or RESET.
- Load port:
  - Honoured only when state == IDLE and READ is low: store[LOADADDR] <= LOADDATA.
  - Ignored in every other case, including when LOADEN and READ are high in the same IDLE cycle; the read wins.
- A load to a block takes effect for any fetch accepted after the load edge.
- A READ still high in IDLE immediately after DONE is treated as a new request and re-accepted.

## Timing
- Reset values: state IDLE, counter 0, latched address 0, READDATA 0, BUSYWAIT 0.
- RESET has priority over all other inputs at the edge. Asserting RESET mid-ACCESS or in DONE aborts the fetch, and the array is unchanged.
- Latency: READ rises before edge E0, and the request is accepted at E0.
  - BUSYWAIT is high from the READ rise through edge E0+LATENCY.
  - READDATA is valid and BUSYWAIT is low in the cycle after E0+LATENCY.
  - The responder is back in IDLE after E0+LATENCY+1.
- The requester must see BUSYWAIT low at edge E0+LATENCY+1 and drop READ before edge E0+LATENCY+2. Otherwise a second fetch starts.
- Back-to-back fetches: minimum spacing of LATENCY+2 edges between acceptances.

## Test plan
- Reset with READ=0 -> READDATA = 0, BUSYWAIT = 0, state IDLE. Then load bytes 0x00..0x0F at addresses 0x000..0x00F.
- Load bytes 0x10..0x1F at 0x010..0x01F, then READ=1 with ADDRESS=1 and LATENCY=4:
  - BUSYWAIT rises the same cycle;
  - after edge E0+4, READDATA = 0x1F1E...1110 and BUSYWAIT = 0 for exactly one cycle;
  - IDLE after E0+5.
- Address 0x3F fetch (top block, bytes 0x3F0..0x3FF) -> correct wrap-free last block. Change ADDRESS to 0x00 mid-ACCESS -> block 0x3F still returned.
- Assert RESET two edges into an ACCESS -> BUSYWAIT = 0 and READDATA = 0 next cycle. A subsequent fetch of the same block returns the preloaded data.
- Drop READ mid-ACCESS -> return to IDLE, READDATA unchanged. A LOADEN pulse during ACCESS or in the same cycle as READ -> array unchanged, verified by a later fetch.
- Two back-to-back fetches (blocks 2 then 5) with the cache model dropping READ in its write cycle -> two distinct correct blocks, acceptances exactly LATENCY+2 edges apart.
